// File: rtl/piso_pkg.sv
// Shared definitions for the piso_tx parallel-in/serial-out transmitter.
package piso_pkg;

    localparam int unsigned DATA_W_DEF = 8;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

    // Bit-counter width able to hold 0..w-1.
    function automatic int unsigned cnt_width(input int unsigned w);
        return (w < 3) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/piso_tx_if.sv
// Word-in / bit-out bus of piso_tx; master is the word source, slave the serializer.
interface piso_tx_if #(
    parameter int unsigned DATA_W = piso_pkg::DATA_W_DEF
) ();

    logic [DATA_W-1:0] din;
    logic              din_valid;
    logic              din_ready;
    logic              sout;
    logic              sout_valid;
    logic              sout_last;
    logic              busy;

    modport master (
        output din, din_valid,
        input  din_ready, sout, sout_valid, sout_last, busy
    );

    modport slave (
        input  din, din_valid,
        output din_ready, sout, sout_valid, sout_last, busy
    );

endinterface

// File: rtl/piso_hold_reg.sv
// One-entry hold buffer parking the next word while a frame is still shifting.
module piso_hold_reg #(
    parameter int unsigned DATA_W = piso_pkg::DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic              unload_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] data_o,
    output logic              full_o
);

    logic [DATA_W-1:0] data_q, data_d;
    logic              full_q, full_d;

    // A load in the same cycle as an unload wins, keeping the entry full.
    always_comb begin
        data_d = data_q;
        full_d = full_q;
        if (unload_i) begin
            data_d = '0;
            full_d = 1'b0;
        end
        if (load_i) begin
            data_d = data_i;
            full_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            data_q <= '0;
            full_q <= 1'b0;
        end else begin
            data_q <= data_d;
            full_q <= full_d;
        end
    end

    assign data_o = data_q;
    assign full_o = full_q;

endmodule

// File: rtl/piso_tx.sv
// Parallel-in/serial-out transmitter: shifter, bit counter and IDLE/SHIFT FSM,
// with a one-word hold buffer so back-to-back frames leave no gap.
module piso_tx
    import piso_pkg::*;
#(
    parameter int unsigned DATA_W    = DATA_W_DEF,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic     clk,
    input  logic     rst,
    piso_tx_if.slave bus
);

    localparam int unsigned       CNT_W    = cnt_width(DATA_W);
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(DATA_W - 1);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic sout_q, sout_d;
    logic sout_valid_q, sout_valid_d;
    logic sout_last_q, sout_last_d;
    logic busy_q, busy_d;

    logic              accept;
    logic              last_bit;
    logic              hold_load;
    logic              hold_unload;
    logic              hold_full;
    logic              hold_full_d;
    logic [DATA_W-1:0] hold_data;
    logic [DATA_W-1:0] shifted;

    piso_hold_reg #(.DATA_W(DATA_W)) u_hold (
        .clk      (clk),
        .rst      (rst),
        .load_i   (hold_load),
        .unload_i (hold_unload),
        .data_i   (bus.din),
        .data_o   (hold_data),
        .full_o   (hold_full)
    );

    assign bus.din_ready = rst & ~hold_full;
    assign accept        = bus.din_valid & bus.din_ready;
    assign last_bit      = (state_q == ST_SHIFT) && (cnt_q == LAST_CNT);
    assign shifted       = MSB_FIRST ? {shift_q[DATA_W-2:0], 1'b0}
                                     : {1'b0, shift_q[DATA_W-1:1]};

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            shift_q      <= '0;
            cnt_q        <= '0;
            sout_q       <= 1'b0;
            sout_valid_q <= 1'b0;
            sout_last_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            cnt_q        <= cnt_d;
            sout_q       <= sout_d;
            sout_valid_q <= sout_valid_d;
            sout_last_q  <= sout_last_d;
            busy_q       <= busy_d;
        end
    end

    // Next state: a new word may load straight into the shifter only when the
    // shifter is free (IDLE) or releasing its final bit this cycle.
    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        cnt_d       = cnt_q;
        hold_load   = 1'b0;
        hold_unload = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_SHIFT;
                    shift_d = bus.din;
                    cnt_d   = '0;
                end
            end
            ST_SHIFT: begin
                if (last_bit) begin
                    cnt_d = '0;
                    if (accept) begin
                        shift_d = bus.din;
                    end else if (hold_full) begin
                        shift_d     = hold_data;
                        hold_unload = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        shift_d = '0;
                    end
                end else begin
                    shift_d   = shifted;
                    cnt_d     = cnt_q + CNT_W'(1);
                    hold_load = accept;
                end
            end
            default: begin
                state_d = ST_IDLE;
                shift_d = '0;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are computed from next-state values so they land in flops.
    always_comb begin
        hold_full_d  = hold_load | (hold_full & ~hold_unload);
        sout_valid_d = (state_d == ST_SHIFT);
        sout_d       = 1'b0;
        if (sout_valid_d) begin
            sout_d = MSB_FIRST ? shift_d[DATA_W-1] : shift_d[0];
        end
        sout_last_d  = sout_valid_d && (cnt_d == LAST_CNT);
        busy_d       = sout_valid_d | hold_full_d;
    end

    assign bus.sout       = sout_q;
    assign bus.sout_valid = sout_valid_q;
    assign bus.sout_last  = sout_last_q;
    assign bus.busy       = busy_q;

endmodule

// File: doc/piso_tx.md
PISO_TX -- requirements
Module: piso_tx

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, giving the word width in bits (minimum 2).
REQ-002 The block SHALL have parameter MSB_FIRST, default 1: 1 sends bit DATA_W-1 first, 0 sends bit 0 first.
REQ-003 Port clk, input, 1 bit: the single clock; every register updates on its rising edge.
REQ-004 Port rst, input, 1 bit: reset, synchronous and active-low.
REQ-005 Port din, input, DATA_W bits: parallel word to serialize.
REQ-006 Port din_valid, input, 1 bit: din holds a word offered by the source.
REQ-007 Port din_ready, output, 1 bit: the block can accept a word this cycle.
REQ-008 Port sout, output, 1 bit: registered serial data bit.
REQ-009 Port sout_valid, output, 1 bit: sout carries a frame bit this cycle.
REQ-010 Port sout_last, output, 1 bit: sout carries the final bit of a word.
REQ-011 Port busy, output, 1 bit: the shifter or the hold buffer holds data.

Function
REQ-012 A word SHALL be accepted on any rising edge where din_valid=1 and din_ready=1; the source must hold din stable while din_valid=1 and din_ready=0.
REQ-013 din_ready SHALL be derived combinationally as rst AND (hold buffer empty).
REQ-014 The FSM SHALL have two states, IDLE and SHIFT, plus one-entry hold buffer state HOLD_FULL.
REQ-015 Accept in IDLE, or in SHIFT on the last-bit cycle: the word SHALL load directly into the shifter, the state becomes or stays SHIFT, and the bit counter is set to 0.
REQ-016 Accept in SHIFT on any other cycle: the word SHALL go into the hold buffer.
REQ-017 On the last-bit cycle with the hold buffer full, the hold word SHALL move to the shifter and the hold buffer SHALL empty, so the next frame starts with no gap.
REQ-018 On the last-bit cycle with no accept and the hold buffer empty, the state SHALL return to IDLE.
REQ-019 Latency: a word accepted at edge E SHALL present its first bit on sout in the cycle after E, if it loaded directly.
REQ-020 Each frame SHALL occupy exactly DATA_W consecutive sout_valid cycles.
REQ-021 The bit counter SHALL count 0..DATA_W-1 with no wrap beyond DATA_W-1.
REQ-022 sout_last SHALL be 1 only when the counter is DATA_W-1 and the state is SHIFT.
REQ-023 In IDLE, sout, sout_valid and sout_last SHALL be 0.
REQ-024 busy SHALL be 1 when the state is SHIFT or the hold buffer is full.
REQ-025 Bit order SHALL follow MSB_FIRST; bits shifted out SHALL be replaced with 0.

Reset
REQ-026 On a rising edge with rst=0, the block SHALL go to IDLE, clear the shifter, hold buffer and counter to 0, and drive sout, sout_valid, sout_last and busy to 0.
REQ-027 While rst=0, din_ready SHALL be 0.
REQ-028 Reset in the middle of a frame SHALL drop both the partial frame and the held word, with no sout_last emitted.
REQ-029 In the first cycle after rst rises, din_ready SHALL be 1.

Structure
REQ-030 Shared package piso_pkg SHALL hold the DATA_W default, the state encoding (IDLE, SHIFT) and the counter-width function.
REQ-031 The one-entry hold buffer SHALL be a sub-module, piso_hold_reg, with ports: load, unload, data in, data out, full.
REQ-032 The shifter, counter and FSM SHALL reside in piso_tx.

Verification
REQ-033 Single word: DATA_W=8, MSB_FIRST=1, 0xA5 accepted at edge E -> sout = 1,0,1,0,0,1,0,1 in cycles E+1..E+8; sout_last only at E+8; IDLE at E+9.
REQ-034 Back-to-back: 0xA5 then 0x3C, din_valid held 1 -> 16 contiguous sout_valid cycles; sout_last at cycles 8 and 16; din_ready=0 while the hold buffer is full.
REQ-035 Backpressure: three words offered continuously -> the third is accepted only in the cycle after the first word's last bit; no word is lost or duplicated.
REQ-036 LSB-first: MSB_FIRST=0, word 0x01 -> sout = 1,0,0,0,0,0,0,0.
REQ-037 Reset mid-frame: rst=0 at bit 3 of 0xFF with 0x55 held -> next cycle all outputs 0; after rst rises, din_ready=1 and no stale bits appear.
REQ-038 Idle: no din_valid for 20 cycles -> sout=0, sout_valid=0, busy=0 throughout.
